// File: rtl/fp_mul_scheduler_if.sv
// Request/response bundle between NUM_REQ lane controllers and fp_mul_scheduler.
// Operands are packed per requester: requester i occupies bits [32i+31:32i].
interface fp_mul_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [32*NUM_REQ-1:0] req_datab;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;

  modport master (
    output req_valid, req_dataa, req_datab, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_dataa, req_datab, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/fp_mul_scheduler.sv
// Round-robin sharing of one combinational fp multiplier across NUM_REQ requesters,
// LAT-stage pipeline with response backpressure. Optional counters: FP_MUL_SCHED_STATS_EN.
module fp_mul_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  fp_mul_scheduler_if.slave   bus,
  output logic [31:0]         mul_dataa,
  output logic [31:0]         mul_datab,
  input  logic [31:0]         mul_result
`ifdef FP_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_stall
`endif
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant;
  logic           grant_found;
  logic [IdW:0]   idx;
  logic           advance;
  logic           accept;

  logic           s1_valid_q;
  logic [IdW-1:0] s1_id_q;
  logic [31:0]    opa_q, opb_q;

  logic           vld_q [2:LAT];
  logic [IdW-1:0] id_q  [2:LAT];
  logic [31:0]    res_q [2:LAT];

  logic           out_valid;
  logic [IdW-1:0] out_id;

  assign out_valid = vld_q[LAT];
  assign out_id    = id_q[LAT];
  assign advance   = !out_valid || bus.rsp_ready[out_id];
  assign accept    = advance && grant_found;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (IdW+1)'(k);
      if (idx >= (IdW+1)'(NUM_REQ)) idx = idx - (IdW+1)'(NUM_REQ);
      if (!grant_found && bus.req_valid[idx[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant       = idx[IdW-1:0];
      end
    end
  end

  assign ptr_d = (grant == IdW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = out_valid && (out_id == IdW'(i));
    end
  end

  assign bus.rsp_result = res_q[LAT];
  assign mul_dataa      = opa_q;
  assign mul_datab      = opb_q;

  // The whole pipeline, operand stage included, freezes while the output is blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      for (int unsigned s = 2; s <= LAT; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
        res_q[s] <= '0;
      end
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        ptr_q   <= ptr_d;
        s1_id_q <= grant;
        opa_q   <= bus.req_dataa[{grant, 5'd0} +: 32];
        opb_q   <= bus.req_datab[{grant, 5'd0} +: 32];
      end
      vld_q[2] <= s1_valid_q;
      id_q[2]  <= s1_id_q;
      res_q[2] <= mul_result;
      for (int unsigned s = 3; s <= LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
        res_q[s] <= res_q[s-1];
      end
    end
  end

`ifdef FP_MUL_SCHED_STATS_EN
  logic [31:0] ops_q, stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (accept && (ops_q != 32'hFFFF_FFFF))                 ops_q   <= ops_q + 32'd1;
      if (!advance && (stall_q != 32'hFFFF_FFFF))             stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_ops   = ops_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler: a 4-requester instance and a 1-requester instance,
// each backed by a simple fp multiply model (exact for the short-mantissa operands used).
module tb_fp_mul_scheduler;

  localparam logic [31:0] F0_5 = 32'h3F00_0000;
  localparam logic [31:0] FN05 = 32'hBF00_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F1_5 = 32'h3FC0_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] F5   = 32'h40A0_0000;
  localparam logic [31:0] F6   = 32'h40C0_0000;
  localparam logic [31:0] F8   = 32'h4100_0000;
  localparam logic [31:0] F10  = 32'h4120_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fp_mul_scheduler_if #(.NUM_REQ(4)) bus4 ();
  fp_mul_scheduler_if #(.NUM_REQ(1)) bus1 ();

  logic [31:0] mula4, mulb4, mulr4, mula1, mulb1, mulr1;
`ifdef FP_MUL_SCHED_STATS_EN
  logic [31:0] ops4, stall4, ops1, stall1;
`endif

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [8:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
    if (m[47]) begin
      e = e + 9'd1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  assign mulr4 = fmul(mula4, mulb4);
  assign mulr1 = fmul(mula1, mulb1);

  fp_mul_scheduler #(.NUM_REQ(4), .LAT(2)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus4),
    .mul_dataa  (mula4),
    .mul_datab  (mulb4),
    .mul_result (mulr4)
`ifdef FP_MUL_SCHED_STATS_EN
    ,
    .stat_ops   (ops4),
    .stat_stall (stall4)
`endif
  );

  fp_mul_scheduler #(.NUM_REQ(1), .LAT(2)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus1),
    .mul_dataa  (mula1),
    .mul_datab  (mulb1),
    .mul_result (mulr1)
`ifdef FP_MUL_SCHED_STATS_EN
    ,
    .stat_ops   (ops1),
    .stat_stall (stall1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus4.req_dataa[32*i +: 32] = a;
    bus4.req_datab[32*i +: 32] = b;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus4.req_valid = '0;
    bus4.rsp_ready = '1;
    bus4.req_dataa = '0;
    bus4.req_datab = '0;
    bus1.req_valid = '0;
    bus1.rsp_ready = '1;
    bus1.req_dataa = '0;
    bus1.req_datab = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0000) begin bad++;
      $display("FAIL reset_req_ready got %b want 0000", bus4.req_ready); end
    total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
      $display("FAIL reset_rsp_valid got %b want 0000", bus4.rsp_valid); end
    total++; if (bus4.rsp_result !== 32'h0) begin bad++;
      $display("FAIL reset_rsp_result got %h want 0", bus4.rsp_result); end
    total++; if (mula4 !== 32'h0 || mulb4 !== 32'h0) begin bad++;
      $display("FAIL reset_mul_operands got %h/%h want 0/0", mula4, mulb4); end
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++;
      $display("FAIL reset_rsp_valid_n1 got %b want 0", bus1.rsp_valid); end
    tick();
  endtask

  task automatic test_single();
    bus4.req_valid = 4'b0001;
    set_op(0, F1, F2);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0001) begin bad++;
      $display("FAIL single_req_ready got %b want 0001", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
      $display("FAIL single_early_rsp got %b want 0000", bus4.rsp_valid); end
    total++; if (mula4 !== F1) begin bad++;
      $display("FAIL single_mul_dataa got %h want %h", mula4, F1); end
    tick();
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0001) begin bad++;
      $display("FAIL single_rsp_valid got %b want 0001", bus4.rsp_valid); end
    total++; if (bus4.rsp_result !== F2) begin bad++;
      $display("FAIL single_rsp_result got %h want %h", bus4.rsp_result, F2); end
    tick();
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
      $display("FAIL single_rsp_one_cycle got %b want 0000", bus4.rsp_valid); end
    tick();
  endtask

  task automatic test_req2();
    bus4.req_valid = 4'b0100;
    set_op(2, F3, FN05);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0100) begin bad++;
      $display("FAIL req2_req_ready got %b want 0100", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (mula4 !== F3) begin bad++;
      $display("FAIL req2_mul_dataa got %h want %h", mula4, F3); end
    tick();
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0100) begin bad++;
      $display("FAIL req2_rsp_valid got %b want 0100", bus4.rsp_valid); end
    total++; if (bus4.rsp_result !== 32'hBFC0_0000) begin bad++;
      $display("FAIL req2_rsp_result got %h want bfc00000", bus4.rsp_result); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] prod [4];
    logic [3:0]  exp_oh;
    prod[0] = F2; prod[1] = F4; prod[2] = F6; prod[3] = F8;
    apply_reset();
    set_op(0, F1, F2);
    set_op(1, F2, F2);
    set_op(2, F3, F2);
    set_op(3, F4, F2);
    for (int c = 0; c <= 10; c++) begin
      bus4.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 8) begin
        exp_oh = 4'b0001 << (c % 4);
        total++; if (bus4.req_ready !== exp_oh) begin bad++;
          $display("FAIL rr_grant c=%0d got %b want %b", c, bus4.req_ready, exp_oh); end
      end
      if (c >= 2 && c < 10) begin
        exp_oh = 4'b0001 << ((c - 2) % 4);
        total++; if (bus4.rsp_valid !== exp_oh || bus4.rsp_result !== prod[(c-2)%4]) begin
          bad++;
          $display("FAIL rr_rsp c=%0d got %b/%h want %b/%h", c, bus4.rsp_valid,
                   bus4.rsp_result, exp_oh, prod[(c-2)%4]);
        end
      end else begin
        total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
          $display("FAIL rr_idle c=%0d got %b want 0000", c, bus4.rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bus4.req_valid = 4'b0010;
    set_op(1, F2, F3);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0010) begin bad++;
      $display("FAIL stall_req1_ready got %b want 0010", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0100;
    set_op(2, F1, F1_5);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0100) begin bad++;
      $display("FAIL stall_req2_ready got %b want 0100", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0001;
    set_op(0, F4, F0_5);
    bus4.rsp_ready = 4'b1101;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total++; if (bus4.rsp_valid !== 4'b0010 || bus4.rsp_result !== F6) begin bad++;
        $display("FAIL stall_hold s=%0d got %b/%h want 0010/%h", s, bus4.rsp_valid,
                 bus4.rsp_result, F6); end
      total++; if (bus4.req_ready !== 4'b0000) begin bad++;
        $display("FAIL stall_no_accept s=%0d got %b want 0000", s, bus4.req_ready); end
      total++; if (mula4 !== F1) begin bad++;
        $display("FAIL stall_s1_hold s=%0d got %h want %h", s, mula4, F1); end
      tick();
    end
    bus4.rsp_ready = 4'b1111;
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0010 || bus4.req_ready !== 4'b0001) begin bad++;
      $display("FAIL stall_release got rsp %b rdy %b want 0010/0001", bus4.rsp_valid,
               bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0000;
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0100 || bus4.rsp_result !== F1_5) begin bad++;
      $display("FAIL stall_drain_req2 got %b/%h want 0100/%h", bus4.rsp_valid,
               bus4.rsp_result, F1_5); end
    tick();
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0001 || bus4.rsp_result !== F2) begin bad++;
      $display("FAIL stall_drain_req0 got %b/%h want 0001/%h", bus4.rsp_valid,
               bus4.rsp_result, F2); end
    tick();
    @(negedge clk);
    total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
      $display("FAIL stall_no_dup got %b want 0000", bus4.rsp_valid); end
`ifdef FP_MUL_SCHED_STATS_EN
    total++; if (stall4 !== 32'd3) begin bad++;
      $display("FAIL stall_stat got %0d want 3", stall4); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bus4.req_valid = 4'b1000;
    set_op(3, F2, F2);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b1000) begin bad++;
      $display("FAIL rstmid_req3_ready got %b want 1000", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0001;
    set_op(0, F3, F3);
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0001) begin bad++;
      $display("FAIL rstmid_req0_ready got %b want 0001", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0000;
    #1;
    total++; if (bus4.rsp_valid !== 4'b1000) begin bad++;
      $display("FAIL rstmid_inflight got %b want 1000", bus4.rsp_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (bus4.rsp_valid !== 4'b0000 || mula4 !== 32'h0) begin bad++;
      $display("FAIL rstmid_async got %b/%h want 0000/0", bus4.rsp_valid, mula4); end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (bus4.rsp_valid !== 4'b0000) begin bad++;
        $display("FAIL rstmid_ghost c=%0d got %b want 0000", c, bus4.rsp_valid); end
      tick();
    end
    bus4.req_valid = 4'b1111;
    @(negedge clk);
    total++; if (bus4.req_ready !== 4'b0001) begin bad++;
      $display("FAIL rstmid_ptr got %b want 0001", bus4.req_ready); end
    tick();
    bus4.req_valid = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [5];
    logic [31:0] prod [5];
    a[0] = F1; a[1] = F2; a[2] = F3; a[3] = F4; a[4] = F5;
    prod[0] = F2; prod[1] = F4; prod[2] = F6; prod[3] = F8; prod[4] = F10;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        bus1.req_valid = 1'b1;
        bus1.req_dataa = a[c];
        bus1.req_datab = F2;
      end else begin
        bus1.req_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 5) begin
        total++; if (bus1.req_ready !== 1'b1) begin bad++;
          $display("FAIL b2b_ready c=%0d got %b want 1", c, bus1.req_ready); end
      end
      if (c >= 2 && c < 7) begin
        total++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_result !== prod[c-2]) begin bad++;
          $display("FAIL b2b_rsp c=%0d got %b/%h want 1/%h", c, bus1.rsp_valid,
                   bus1.rsp_result, prod[c-2]); end
      end else begin
        total++; if (bus1.rsp_valid !== 1'b0) begin bad++;
          $display("FAIL b2b_idle c=%0d got %b want 0", c, bus1.rsp_valid); end
      end
      tick();
    end
`ifdef FP_MUL_SCHED_STATS_EN
    total++; if (ops1 !== 32'd5) begin bad++;
      $display("FAIL b2b_stat_ops got %0d want 5", ops1); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_req2();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
